// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word width, RAM status and memory-controller states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } memctl_state_t;

endpackage

// File: rtl/cache_control_if.sv
// Bundle between per-CPU cache pairs, the memory controller and the RAM.
interface cache_control_if #(parameter int CPUS = 2);
    import cpu_types_pkg::*;

    logic [CPUS-1:0] iREN, dREN, dWEN;
    logic [CPUS-1:0] iwait, dwait;
    word_t           iaddr  [CPUS];
    word_t           daddr  [CPUS];
    word_t           dstore [CPUS];
    word_t           iload  [CPUS];
    word_t           dload  [CPUS];

    ramstate_t       ramstate;
    word_t           ramload;
    word_t           ramaddr, ramstore;
    logic            ramREN, ramWEN;

    modport cc (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        int unsigned        pos;
        logic [IDX_W-1:0]   k;
        any     = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) pos = pos - N;
            k = IDX_W'(pos);
            if (!any && req[k]) begin
                any     = 1'b1;
                gnt_idx = k;
            end
        end
    end

endmodule

// File: rtl/multicore_memory_control.sv
// Single-port RAM arbiter serving CPUS instruction/data cache pairs round-robin.
module multicore_memory_control
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input logic        CLK,
    input logic        nRST,
    cache_control_if.cc ccif
);

    localparam int N     = 2 * CPUS;
    localparam int IDX_W = $clog2(N);

    memctl_state_t    state, next_state;
    logic [IDX_W-1:0] grant, next_grant;
    logic [IDX_W-1:0] rr_ptr, next_ptr;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [N-1:0]     req;
    logic [N-1:0]     w;

    logic              g_req, g_ren, g_wen;
    logic [WORD_W-1:0] g_addr, g_store;

    // Requester r = 2*cpu + kind, kind 0 = data, 1 = instruction.
    for (genvar c = 0; c < CPUS; c++) begin : g_cpu
        assign req[2*c]     = ccif.dREN[c] | ccif.dWEN[c];
        assign req[2*c+1]   = ccif.iREN[c];
        assign ccif.dwait[c] = w[2*c];
        assign ccif.iwait[c] = w[2*c+1];
        assign ccif.dload[c] = ccif.ramload;
        assign ccif.iload[c] = ccif.ramload;
    end

    rr_arbiter #(.N(N)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Live view of the granted requester; a write beats a read on the same data port.
    always_comb begin
        g_req   = 1'b0;
        g_ren   = 1'b0;
        g_wen   = 1'b0;
        g_addr  = '0;
        g_store = '0;
        for (int unsigned c = 0; c < CPUS; c++) begin
            if (grant == IDX_W'(2*c)) begin
                g_req   = ccif.dREN[c] | ccif.dWEN[c];
                g_wen   = ccif.dWEN[c];
                g_ren   = ccif.dREN[c] & ~ccif.dWEN[c];
                g_addr  = ccif.daddr[c];
                g_store = ccif.dstore[c];
            end else if (grant == IDX_W'(2*c+1)) begin
                g_req  = ccif.iREN[c];
                g_ren  = ccif.iREN[c];
                g_addr = ccif.iaddr[c];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= next_state;
            grant  <= next_grant;
            rr_ptr <= next_ptr;
        end
    end

    always_comb begin
        next_state    = state;
        next_grant    = grant;
        next_ptr      = rr_ptr;
        w             = '1;
        ccif.ramREN   = 1'b0;
        ccif.ramWEN   = 1'b0;
        ccif.ramaddr  = '0;
        ccif.ramstore = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    next_grant = arb_idx;
                    next_state = GRANT;
                end
            end
            GRANT: begin
                // A withdrawn request aborts without touching rr_ptr.
                if (!g_req) begin
                    next_state = IDLE;
                end else begin
                    ccif.ramREN   = g_ren;
                    ccif.ramWEN   = g_wen;
                    ccif.ramaddr  = g_addr;
                    ccif.ramstore = g_store;
                    if (ccif.ramstate == ACCESS) begin
                        w[grant]   = 1'b0;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_ptr   = (grant == IDX_W'(N-1)) ? '0 : grant + IDX_W'(1);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicore_memory_control.sv
// Randomized bench for multicore_memory_control against a transaction-level round-robin model.
module tb_multicore_memory_control;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int N    = 2 * CPUS;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    cache_control_if #(.CPUS(CPUS)) ccif ();

    multicore_memory_control #(.CPUS(CPUS), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ccif (ccif)
    );

    int tests = 0;
    int fails = 0;

    bit        d_rd [CPUS];
    bit        d_wr [CPUS];
    bit        i_rd [CPUS];
    word_t     d_a  [CPUS];
    word_t     d_s  [CPUS];
    word_t     i_a  [CPUS];
    word_t     rl;
    ramstate_t rs;

    // Model: phase 0 = waiting to pick, 1 = serving m_grant, 2 = completion cooldown.
    int m_phase, m_grant, m_ptr;
    bit done_r [N];
    int obs_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pending(input int r);
        int c = r / 2;
        return (r % 2 == 0) ? (d_rd[c] | d_wr[c]) : i_rd[c];
    endfunction

    task automatic apply();
        for (int c = 0; c < CPUS; c++) begin
            ccif.dREN[c]   = d_rd[c];
            ccif.dWEN[c]   = d_wr[c];
            ccif.iREN[c]   = i_rd[c];
            ccif.daddr[c]  = d_a[c];
            ccif.dstore[c] = d_s[c];
            ccif.iaddr[c]  = i_a[c];
        end
        ccif.ramstate = rs;
        ccif.ramload  = rl;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_grant = 0;
        for (int r = 0; r < N; r++) done_r[r] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        for (int c = 0; c < CPUS; c++) begin
            chk({tag, "_dwait"}, 64'(ccif.dwait[c]), 64'd1);
            chk({tag, "_iwait"}, 64'(ccif.iwait[c]), 64'd1);
        end
        chk({tag, "_ren"},   64'(ccif.ramREN),   64'd0);
        chk({tag, "_wen"},   64'(ccif.ramWEN),   64'd0);
        chk({tag, "_addr"},  64'(ccif.ramaddr),  64'd0);
        chk({tag, "_store"}, 64'(ccif.ramstore), 64'd0);
    endtask

    // Compare this cycle's outputs, then advance the model across the coming edge.
    task automatic check_cycle();
        logic [N-1:0] ew;
        logic         eren, ewen;
        word_t        ea, es;
        int           gc;
        ew = '1; eren = 1'b0; ewen = 1'b0; ea = '0; es = '0;
        if (m_phase == 1 && pending(m_grant)) begin
            gc = m_grant / 2;
            if (m_grant % 2 == 1) begin
                eren = 1'b1;
                ea   = i_a[gc];
            end else begin
                ewen = d_wr[gc];
                eren = !d_wr[gc];
                ea   = d_a[gc];
                es   = d_s[gc];
            end
            if (rs == ACCESS) ew[m_grant] = 1'b0;
        end
        for (int c = 0; c < CPUS; c++) begin
            chk("dwait", 64'(ccif.dwait[c]), 64'(ew[2*c]));
            chk("iwait", 64'(ccif.iwait[c]), 64'(ew[2*c+1]));
            chk("dload", 64'(ccif.dload[c]), 64'(rl));
            chk("iload", 64'(ccif.iload[c]), 64'(rl));
            if (ccif.dwait[c] === 1'b0) obs_q.push_back(2*c);
            if (ccif.iwait[c] === 1'b0) obs_q.push_back(2*c+1);
        end
        chk("ramREN",   64'(ccif.ramREN),   64'(eren));
        chk("ramWEN",   64'(ccif.ramWEN),   64'(ewen));
        chk("ramaddr",  64'(ccif.ramaddr),  64'(ea));
        chk("ramstore", 64'(ccif.ramstore), 64'(es));
        for (int r = 0; r < N; r++) done_r[r] = (ew[r] == 1'b0);

        case (m_phase)
            0: begin
                for (int i = 0; i < N; i++) begin
                    if (pending((m_ptr + i) % N)) begin
                        m_grant = (m_ptr + i) % N;
                        m_phase = 1;
                        break;
                    end
                end
            end
            1: begin
                if (!pending(m_grant)) m_phase = 0;
                else if (rs == ACCESS) m_phase = 2;
            end
            default: begin
                m_ptr   = (m_grant + 1) % N;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic randomize_inputs();
        int k;
        for (int c = 0; c < CPUS; c++) begin
            if (d_rd[c] | d_wr[c]) begin
                if ($urandom_range(0, done_r[2*c] ? 1 : 11) == 0) begin
                    d_rd[c] = 1'b0;
                    d_wr[c] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 2);
                d_rd[c] = (k != 1);
                d_wr[c] = (k != 0);
                d_a[c]  = $urandom;
                d_s[c]  = $urandom;
            end
            if (i_rd[c]) begin
                if ($urandom_range(0, done_r[2*c+1] ? 1 : 11) == 0) i_rd[c] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_rd[c] = 1'b1;
                i_a[c]  = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                d_a[c] = $urandom;
                d_s[c] = $urandom;
                i_a[c] = $urandom;
            end
        end
        k = $urandom_range(0, 19);
        if (k < 8)       rs = ACCESS;
        else if (k < 14) rs = BUSY;
        else if (k < 17) rs = ERROR;
        else             rs = FREE;
        rl = $urandom;
        apply();
    endtask

    initial begin
        int ord [5];
        ord = '{0, 1, 2, 3, 0};
        nRST = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            d_rd[c] = 1'b0; d_wr[c] = 1'b0; i_rd[c] = 1'b0;
            d_a[c] = '0; d_s[c] = '0; i_a[c] = '0;
        end
        rs = FREE;
        rl = 32'h0;
        apply();
        model_reset();
        #2;
        check_idle("reset");

        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Every requester held with immediate ACCESS: strict rotation 0,1,2,3,0.
        for (int c = 0; c < CPUS; c++) begin
            d_rd[c] = 1'b1;
            i_rd[c] = 1'b1;
            d_a[c]  = 32'h100 + 32'(c);
            i_a[c]  = 32'h200 + 32'(c);
        end
        rs = ACCESS;
        rl = 32'hDEADBEEF;
        apply();
        obs_q.delete();
        repeat (15) begin
            @(negedge CLK);
            check_cycle();
            @(posedge CLK);
            #1;
        end
        chk("order_count", 64'(obs_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) chk("order", 64'(obs_q[i]), 64'(ord[i]));

        for (int c = 0; c < CPUS; c++) begin
            d_rd[c] = 1'b0;
            i_rd[c] = 1'b0;
        end

        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            @(negedge CLK);
            if ($urandom_range(0, 149) == 0) begin
                nRST = 1'b0;
                #1;
                check_idle("rst_mid");
                model_reset();
                @(posedge CLK);
                #1;
                check_idle("rst_hold");
                @(negedge CLK);
                nRST = 1'b1;
                #1;
                check_cycle();
            end else begin
                check_cycle();
            end
            @(posedge CLK);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
